// File: rtl/sram_ctrl_pkg.sv
// Shared types and geometry for the 128x312 single-port SRAM controller.
package sram_ctrl_pkg;

    localparam int unsigned SramDepth     = 128;
    localparam int unsigned SramWidth     = 312;
    localparam int unsigned SramMaskWidth = 8;
    localparam int unsigned SramAddrW     = $clog2(SramDepth);

    typedef enum logic {
        INIT  = 1'b0,
        SERVE = 1'b1
    } state_e;

    // One array-port command as presented by a requester or the zeroize sweep.
    typedef struct packed {
        logic                     write;
        logic [SramAddrW-1:0]     addr;
        logic [SramMaskWidth-1:0] wmask;
        logic [SramWidth-1:0]     wdata;
    } sram_cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, priority flips away
// from whichever port was granted.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output logic       valid_o
);

    // 0: port 0 wins a tie, 1: port 1 wins a tie.
    logic prio_q;

    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first, so no branch can leave it unassigned and infer a latch.
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

    assign valid_o = |req_i;

    // NOTE: reset is synchronous and active-high, so it lives inside the
    // clocked block rather than in the sensitivity list.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= 1'b0;
        end else if (valid_o) begin
            // NOTE: state registers use non-blocking assignment so every flop
            // samples its inputs from before the edge.
            prio_q <= gnt_o[0];
        end
    end

endmodule

// File: rtl/sram_ctrl_1p128x312.sv
// Single-port 128x312 SRAM controller: zeroize sweep, two-port round-robin
// access, and one-cycle read return routed to the issuing port.
module sram_ctrl_1p128x312
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned Depth       = SramDepth,
    parameter int unsigned Width       = SramWidth,
    parameter int unsigned MaskWidth   = SramMaskWidth,
    parameter bit          InitOnReset = 1'b1,
    localparam int unsigned AddrW      = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 init_req_i,
    output logic                 init_done_o,

    input  logic                 a_req_i,
    input  logic                 a_write_i,
    input  logic [AddrW-1:0]     a_addr_i,
    input  logic [MaskWidth-1:0] a_wmask_i,
    input  logic [Width-1:0]     a_wdata_i,
    output logic                 a_gnt_o,
    output logic                 a_rvalid_o,
    output logic [Width-1:0]     a_rdata_o,

    input  logic                 b_req_i,
    input  logic                 b_write_i,
    input  logic [AddrW-1:0]     b_addr_i,
    input  logic [MaskWidth-1:0] b_wmask_i,
    input  logic [Width-1:0]     b_wdata_i,
    output logic                 b_gnt_o,
    output logic                 b_rvalid_o,
    output logic [Width-1:0]     b_rdata_o,

    output logic                 sram_req_o,
    output logic                 sram_write_o,
    output logic [AddrW-1:0]     sram_addr_o,
    output logic [MaskWidth-1:0] sram_wmask_o,
    output logic [Width-1:0]     sram_wdata_o,
    input  logic [Width-1:0]     sram_rdata_i
);

    state_e           state_q, state_d;
    logic [AddrW-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             a_rvalid_q, b_rvalid_q;

    logic             arb_en;
    logic [1:0]       arb_req;
    logic [1:0]       arb_gnt;
    logic             arb_valid;

    sram_cmd_t        a_cmd, b_cmd, cmd;
    logic             sram_req;

    assign a_cmd = '{write: a_write_i, addr: a_addr_i, wmask: a_wmask_i, wdata: a_wdata_i};
    assign b_cmd = '{write: b_write_i, addr: b_addr_i, wmask: b_wmask_i, wdata: b_wdata_i};

    // A zeroize request takes the port for this cycle, so nobody is granted.
    assign arb_en  = !rst_i && (state_q == SERVE) && !init_req_i;
    assign arb_req = {b_req_i, a_req_i} & {2{arb_en}};

    rr_arb2 u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (arb_req),
        .gnt_o   (arb_gnt),
        .valid_o (arb_valid)
    );

    assign a_gnt_o = arb_gnt[0];
    assign b_gnt_o = arb_gnt[1];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        sram_req = 1'b0;
        cmd      = '0;
        if (!rst_i) begin
            unique case (state_q)
                INIT: begin
                    sram_req   = 1'b1;
                    cmd.write  = 1'b1;
                    cmd.addr   = cnt_q;
                    cmd.wmask  = '1;
                    cmd.wdata  = '0;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == AddrW'(Depth - 1)) begin
                        state_d = SERVE;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                    end
                end
                SERVE: begin
                    if (init_req_i) begin
                        state_d = INIT;
                        cnt_d   = '0;
                        done_d  = 1'b0;
                    end else if (arb_valid) begin
                        sram_req = 1'b1;
                        cmd      = arb_gnt[1] ? b_cmd : a_cmd;
                        // Reads must never disturb the row, whatever mask the client left on the bus.
                        if (!cmd.write) begin
                            cmd.wmask = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= InitOnReset ? INIT : SERVE;
            cnt_q      <= '0;
            done_q     <= !InitOnReset;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            a_rvalid_q <= arb_gnt[0] & ~a_write_i;
            b_rvalid_q <= arb_gnt[1] & ~b_write_i;
        end
    end

    assign init_done_o  = done_q;

    assign sram_req_o   = sram_req;
    assign sram_write_o = cmd.write;
    assign sram_addr_o  = cmd.addr;
    assign sram_wmask_o = cmd.wmask;
    assign sram_wdata_o = cmd.wdata;

    // Array output is already registered one cycle after the read, so it passes straight through.
    assign a_rvalid_o   = a_rvalid_q;
    assign b_rvalid_o   = b_rvalid_q;
    assign a_rdata_o    = sram_rdata_i;
    assign b_rdata_o    = sram_rdata_i;

endmodule

// File: tb/tb_sram_ctrl_1p128x312.sv
// Scoreboard bench for sram_ctrl_1p128x312 with a behavioural array and a
// lane-level reference memory.
module tb_sram_ctrl_1p128x312;

    localparam int W         = 312;
    localparam int Lane      = 39;
    localparam int Rows      = 128;
    localparam int GntBudget = 400;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         init_req_i = 1'b0;
    logic         init_done_o;

    logic         a_req_i = 1'b0, a_write_i = 1'b0;
    logic [6:0]   a_addr_i = '0;
    logic [7:0]   a_wmask_i = '0;
    logic [W-1:0] a_wdata_i = '0;
    logic         a_gnt_o, a_rvalid_o;
    logic [W-1:0] a_rdata_o;

    logic         b_req_i = 1'b0, b_write_i = 1'b0;
    logic [6:0]   b_addr_i = '0;
    logic [7:0]   b_wmask_i = '0;
    logic [W-1:0] b_wdata_i = '0;
    logic         b_gnt_o, b_rvalid_o;
    logic [W-1:0] b_rdata_o;

    logic         sram_req_o, sram_write_o;
    logic [6:0]   sram_addr_o;
    logic [7:0]   sram_wmask_o;
    logic [W-1:0] sram_wdata_o;
    logic [W-1:0] sram_rdata_i = '0;

    sram_ctrl_1p128x312 dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .init_req_i   (init_req_i),
        .init_done_o  (init_done_o),
        .a_req_i      (a_req_i),
        .a_write_i    (a_write_i),
        .a_addr_i     (a_addr_i),
        .a_wmask_i    (a_wmask_i),
        .a_wdata_i    (a_wdata_i),
        .a_gnt_o      (a_gnt_o),
        .a_rvalid_o   (a_rvalid_o),
        .a_rdata_o    (a_rdata_o),
        .b_req_i      (b_req_i),
        .b_write_i    (b_write_i),
        .b_addr_i     (b_addr_i),
        .b_wmask_i    (b_wmask_i),
        .b_wdata_i    (b_wdata_i),
        .b_gnt_o      (b_gnt_o),
        .b_rvalid_o   (b_rvalid_o),
        .b_rdata_o    (b_rdata_o),
        .sram_req_o   (sram_req_o),
        .sram_write_o (sram_write_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wmask_o (sram_wmask_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_rdata_i (sram_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    logic [W-1:0] array_mem [Rows];
    logic [W-1:0] ref_mem   [Rows];
    logic [W-1:0] exp_a [$];
    logic [W-1:0] exp_b [$];
    logic [W-1:0] arr_row;
    bit           last_gnt;
    int           n_pass = 0;
    int           n_total = 0;
    int           dual_gnt = 0;
    int           wa, wb;

    // Behavioural single-port array: masked lane writes, registered read data.
    always @(posedge clk_i) begin
        if (sram_req_o) begin
            if (sram_write_o) begin
                arr_row = array_mem[sram_addr_o];
                for (int l = 0; l < 8; l++)
                    if (sram_wmask_o[l]) arr_row[l*Lane +: Lane] = sram_wdata_o[l*Lane +: Lane];
                array_mem[sram_addr_o] = arr_row;
            end else begin
                sram_rdata_i <= array_mem[sram_addr_o];
            end
        end
    end

    function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] data,
                                           input logic [7:0] mask);
        logic [W-1:0] r;
        r = old;
        for (int l = 0; l < 8; l++)
            if (mask[l]) r[l*Lane +: Lane] = data[l*Lane +: Lane];
        return r;
    endfunction

    function automatic logic [W-1:0] rand_row();
        logic [319:0] t;
        for (int i = 0; i < 10; i++) t[i*32 +: 32] = $urandom;
        return t[W-1:0];
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic zero_ref();
        for (int r = 0; r < Rows; r++) ref_mem[r] = '0;
    endtask

    task automatic set_port(input bit port, input logic req, input logic wr, input logic [6:0] addr,
                            input logic [7:0] mask, input logic [W-1:0] data);
        if (port) begin
            b_req_i = req; b_write_i = wr; b_addr_i = addr; b_wmask_i = mask; b_wdata_i = data;
        end else begin
            a_req_i = req; a_write_i = wr; a_addr_i = addr; a_wmask_i = mask; a_wdata_i = data;
        end
    endtask

    // Called at a falling edge; holds the command until granted, then records the
    // expected effect and returns at the next falling edge with the request dropped.
    task automatic issue(input bit port, input logic wr, input logic [6:0] addr, input logic [7:0] mask,
                         input logic [W-1:0] data, output int waited);
        logic  gnt, other;
        string pn;
        pn = port ? "b" : "a";
        set_port(port, 1'b1, wr, addr, mask, data);
        waited = 0;
        #1;
        gnt = port ? b_gnt_o : a_gnt_o;
        while (!gnt && waited < GntBudget) begin
            @(negedge clk_i);
            #1;
            waited++;
            gnt = port ? b_gnt_o : a_gnt_o;
        end
        if (!gnt) begin
            check({pn, "_gnt_timeout"}, W'(gnt), W'(1'b1));
            set_port(port, 1'b0, 1'b0, '0, '0, '0);
            return;
        end
        other = port ? a_req_i : b_req_i;
        if (other) check({pn, "_rr_tie"}, W'(port), W'(!last_gnt));
        check({pn, "_fwd_cmd"}, W'({sram_req_o, sram_write_o, sram_addr_o, sram_wmask_o}),
              W'({1'b1, wr, addr, wr ? mask : 8'h00}));
        if (wr) check({pn, "_fwd_wdata"}, sram_wdata_o, data);
        last_gnt = port;
        if (wr) ref_mem[addr] = merge(ref_mem[addr], data, mask);
        else if (port) exp_b.push_back(ref_mem[addr]);
        else exp_a.push_back(ref_mem[addr]);
        @(negedge clk_i);
        set_port(port, 1'b0, 1'b0, '0, '0, '0);
        check({pn, "_rvalid_lat"}, W'(port ? b_rvalid_o : a_rvalid_o), W'(!wr));
    endtask

    // Entered at the falling edge of the first sweep cycle; returns one edge after the last.
    task automatic sweep_check();
        for (int i = 0; i < Rows; i++) begin
            #1;
            check($sformatf("sweep_%0d", i),
                  W'({sram_req_o, sram_write_o, sram_addr_o, sram_wmask_o, |sram_wdata_o,
                      a_gnt_o, b_gnt_o, init_done_o}),
                  W'({1'b1, 1'b1, 7'(i), 8'hFF, 4'b0000}));
            @(negedge clk_i);
        end
        check("init_done_after_sweep", W'(init_done_o), W'(1'b1));
        zero_ref();
    endtask

    task automatic random_traffic(input bit port, input int ops);
        int w;
        for (int k = 0; k < ops; k++) begin
            issue(port, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), 8'($urandom),
                  rand_row(), w);
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end
    endtask

    // Monitor: pops the scoreboard whenever a read return is presented.
    initial begin
        forever begin
            @(negedge clk_i);
            #1;
            if (a_gnt_o && b_gnt_o) dual_gnt++;
            if (a_rvalid_o) begin
                if (exp_a.size() == 0) check("a_rvalid_unexpected", W'(a_rvalid_o), W'(1'b0));
                else check("a_rdata", a_rdata_o, exp_a.pop_front());
            end
            if (b_rvalid_o) begin
                if (exp_b.size() == 0) check("b_rvalid_unexpected", W'(b_rvalid_o), W'(1'b0));
                else check("b_rdata", b_rdata_o, exp_b.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] row;
        for (int r = 0; r < Rows; r++) begin
            array_mem[r] = rand_row();
            ref_mem[r]   = '0;
        end
        last_gnt = 1'b1;

        // Reset state.
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_sram_outputs", W'({sram_req_o, sram_write_o, sram_addr_o, sram_wmask_o, |sram_wdata_o}), '0);
        check("rst_init_done", W'(init_done_o), W'(1'b0));
        check("rst_rvalid", W'({a_rvalid_o, b_rvalid_o}), W'(2'b00));
        rst_i = 1'b0;
        sweep_check();

        // Partial-mask write then read back.
        issue(1'b0, 1'b1, 7'd5, 8'h01, '1, wa);
        issue(1'b0, 1'b0, 7'd5, 8'h00, '0, wa);
        row = '0;
        row[Lane-1:0] = '1;
        check("a_row5_lane0", a_rdata_o, row);
        check("b_rvalid_idle_row5", W'(b_rvalid_o), W'(1'b0));

        // Contention: both ports read continuously, grants must alternate.
        issue(1'b1, 1'b1, 7'd3, 8'hFF, rand_row(), wb);
        issue(1'b1, 1'b1, 7'd4, 8'hFF, rand_row(), wb);
        fork
            begin repeat (4) issue(1'b0, 1'b0, 7'd3, 8'h00, '0, wa); end
            begin repeat (4) issue(1'b1, 1'b0, 7'd4, 8'h00, '0, wb); end
        join

        // Back-to-back reads from B.
        for (int r = 10; r < 13; r++) issue(1'b1, 1'b1, 7'(r), 8'($urandom), rand_row(), wb);
        for (int r = 10; r < 13; r++) begin
            issue(1'b1, 1'b0, 7'(r), 8'h00, '0, wb);
            check("a_rvalid_idle_b2b", W'(a_rvalid_o), W'(1'b0));
        end

        // Randomized mixed traffic on both ports.
        fork
            random_traffic(1'b0, 60);
            random_traffic(1'b1, 60);
        join

        // Zeroize request while A is waiting.
        row = rand_row();
        row[0] = 1'b1;
        issue(1'b0, 1'b1, 7'd7, 8'hFF, row, wa);
        fork
            issue(1'b0, 1'b0, 7'd7, 8'h00, '0, wa);
            begin
                init_req_i = 1'b1;
                #1;
                check("init_req_blocks_sram", W'(sram_req_o), W'(1'b0));
                @(negedge clk_i);
                init_req_i = 1'b0;
                check("init_done_drop", W'(init_done_o), W'(1'b0));
                zero_ref();
            end
        join
        check("init_block_wait", W'(wa), W'(129));

        // Reset in the middle of a sweep restarts it from row 0.
        issue(1'b0, 1'b1, 7'd20, 8'hFF, rand_row(), wa);
        init_req_i = 1'b1;
        @(negedge clk_i);
        init_req_i = 1'b0;
        repeat (60) @(negedge clk_i);
        #1;
        check("sweep_cnt60", W'(sram_addr_o), W'(60));
        rst_i = 1'b1;
        #1;
        check("rst_gates_sram", W'(sram_req_o), W'(1'b0));
        @(negedge clk_i);
        rst_i = 1'b0;
        last_gnt = 1'b1;
        check("rst_init_done_low", W'(init_done_o), W'(1'b0));
        sweep_check();
        issue(1'b0, 1'b0, 7'd20, 8'h00, '0, wa);
        issue(1'b1, 1'b0, 7'd100, 8'h00, '0, wb);
        fork
            random_traffic(1'b0, 30);
            random_traffic(1'b1, 30);
        join

        repeat (3) @(negedge clk_i);
        check("a_pending_reads", W'(exp_a.size()), '0);
        check("b_pending_reads", W'(exp_b.size()), '0);
        check("dual_grant_cycles", W'(dual_gnt), '0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
